// File: rtl/basic_gemm_cim.sv
// Compute-in-memory int8 GEMM macro: 64x4 signed weight array, 4x4 dot product per cycle, four 32-bit accumulators.
// Optional build macro CIM_SATURATE_EN makes accumulation saturate instead of wrapping.
module basic_gemm_cim (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        we,
  input  logic        cime,
  input  logic        partial_sum_e,
  input  logic        reset_output_reg,
  input  logic [3:0]  output_reg,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  output logic [31:0] cim_output
);

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int COLS   = 4;
  localparam int ROWS   = 64;

  logic [31:0]              mem_q [ROWS];
  logic signed [ACC_W-1:0]  acc_q [COLS];
  logic signed [ACC_W-1:0]  acc_d [COLS];
  logic [31:0]              out_q, out_d;
  logic signed [17:0]       sum_c [COLS];
  logic [127:0]             blk_rows;
  logic [5:0]               row_addr;
  logic                     wr_en, cmp_en, clr_en;
  logic                     unused_addr;

  assign unused_addr = ^address[31:6];
  assign row_addr    = address[5:0];

  // Clear outranks write, write outranks compute; dropped strobes have no side effect.
  assign clr_en = cs & reset_output_reg;
  assign wr_en  = cs & we & ~reset_output_reg;
  assign cmp_en = cs & cime & ~we & ~reset_output_reg;

  assign blk_rows = {mem_q[{address[5:2], 2'd3}], mem_q[{address[5:2], 2'd2}],
                     mem_q[{address[5:2], 2'd1}], mem_q[{address[5:2], 2'd0}]};

  function automatic logic signed [17:0] col_dot(input logic [31:0] x,
                                                 input logic [127:0] rows,
                                                 input int c);
    logic signed [DATA_W-1:0] xk, wk;
    logic signed [15:0]       prod;
    logic signed [17:0]       s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      xk   = signed'(x[DATA_W*k +: DATA_W]);
      wk   = signed'(rows[32*k + DATA_W*c +: DATA_W]);
      prod = xk * wk;
      s    = s + {{2{prod[15]}}, prod};
    end
    return s;
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    s = a + b;
`ifdef CIM_SATURATE_EN
    if (!a[ACC_W-1] && !b[ACC_W-1] && s[ACC_W-1])
      s = 32'sh7FFF_FFFF;
    else if (a[ACC_W-1] && b[ACC_W-1] && !s[ACC_W-1])
      s = 32'sh8000_0000;
`endif
    return s;
  endfunction

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      sum_c[c] = col_dot(input_data, blk_rows, c);
      acc_d[c] = acc_q[c];
      if (clr_en)
        acc_d[c] = '0;
      else if (cmp_en)
        acc_d[c] = partial_sum_e ? acc_add(acc_q[c], ACC_W'(sum_c[c])) : ACC_W'(sum_c[c]);
    end
  end

  // Read path reports post-update accumulator or the (write-first) addressed row.
  always_comb begin
    out_d = out_q;
    if (cs) begin
      if (output_reg[0])      out_d = acc_d[0];
      else if (output_reg[1]) out_d = acc_d[1];
      else if (output_reg[2]) out_d = acc_d[2];
      else if (output_reg[3]) out_d = acc_d[3];
      else                    out_d = wr_en ? input_data : mem_q[row_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) acc_q[c] <= '0;
      out_q <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) acc_q[c] <= acc_d[c];
      out_q <= out_d;
    end
  end

  // Weight array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[row_addr] <= input_data;
  end

  assign cim_output = out_q;

endmodule

// File: tb/tb_basic_gemm_cim.sv
// Directed, table-driven bench for basic_gemm_cim, plus async-reset and accumulator overflow sequences.
module tb_basic_gemm_cim;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, we, cime, partial_sum_e, reset_output_reg;
  logic [3:0]  output_reg;
  logic [31:0] address, input_data;
  logic [31:0] cim_output;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cs, we, cime, ps, rso;
    logic [3:0]  oreg;
    logic [31:0] addr, data, exp;
  } vec_t;

  vec_t tbl[$];

  basic_gemm_cim dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .cime(cime),
    .partial_sum_e(partial_sum_e), .reset_output_reg(reset_output_reg),
    .output_reg(output_reg), .address(address), .input_data(input_data),
    .cim_output(cim_output)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic c, w, ci, p, r, input logic [3:0] o,
                     input logic [31:0] a, d, e);
    vec_t v;
    v.cs = c; v.we = w; v.cime = ci; v.ps = p; v.rso = r;
    v.oreg = o; v.addr = a; v.data = d; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic c, w, ci, p, r, input logic [3:0] o,
                       input logic [31:0] a, d);
    cs = c; we = w; cime = ci; partial_sum_e = p; reset_output_reg = r;
    output_reg = o; address = a; input_data = d;
  endtask

  // Drive at negedge, sample 1 time unit after the next posedge, return on negedge.
  task automatic step(input logic c, w, ci, p, r, input logic [3:0] o,
                      input logic [31:0] a, d, e, input string name);
    drive(c, w, ci, p, r, o, a, d);
    @(posedge clk); #1;
    chk(name, cim_output, e);
    @(negedge clk);
  endtask

  initial begin
    //   cs we ci ps rso oreg     addr          data          expected
    add(1, 0, 1, 1, 0, 4'b0001, 32'd0,        32'h0,        32'h0);
    add(1, 1, 0, 0, 0, 4'b0000, 32'd0,        32'h01010101, 32'h01010101);
    add(1, 1, 0, 0, 0, 4'b0000, 32'd1,        32'h02020202, 32'h02020202);
    add(1, 1, 0, 0, 0, 4'b0000, 32'd2,        32'h03030303, 32'h03030303);
    add(1, 1, 0, 0, 0, 4'b0000, 32'd3,        32'h04040404, 32'h04040404);
    add(1, 0, 0, 0, 0, 4'b0000, 32'd2,        32'h0,        32'h03030303);
    add(1, 0, 0, 0, 0, 4'b0000, 32'hFFFFFFC2, 32'h0,        32'h03030303);
    add(1, 0, 1, 0, 0, 4'b0100, 32'd0,        32'h01010101, 32'd10);
    add(1, 0, 1, 1, 0, 4'b0100, 32'd0,        32'h01010101, 32'd20);
    add(1, 0, 1, 1, 1, 4'b0100, 32'd0,        32'h01010101, 32'd0);
    add(1, 0, 1, 0, 0, 4'b0001, 32'd3,        32'h000000FF, 32'hFFFFFFFF);
    add(1, 0, 0, 0, 0, 4'b1000, 32'd0,        32'h0,        32'hFFFFFFFF);
    add(1, 1, 0, 0, 0, 4'b0000, 32'd16,       32'h04030201, 32'h04030201);
    add(1, 1, 0, 0, 0, 4'b0000, 32'd17,       32'h0,        32'h0);
    add(1, 1, 0, 0, 0, 4'b0000, 32'd18,       32'h0,        32'h0);
    add(1, 1, 0, 0, 0, 4'b0000, 32'd19,       32'h0,        32'h0);
    add(1, 0, 1, 0, 0, 4'b1111, 32'd16,       32'h00000003, 32'd3);
    add(1, 0, 0, 0, 0, 4'b0110, 32'd0,        32'h0,        32'd6);
    add(1, 0, 0, 0, 0, 4'b1000, 32'd0,        32'h0,        32'd12);
    add(1, 0, 1, 1, 0, 4'b0100, 32'd17,       32'h000000FE, 32'd3);
    add(1, 0, 0, 0, 0, 4'b1000, 32'd0,        32'h0,        32'd4);
    add(0, 1, 0, 0, 0, 4'b0000, 32'd2,        32'hDEADBEEF, 32'd4);
    add(1, 0, 0, 0, 0, 4'b0000, 32'd2,        32'h0,        32'h03030303);
    add(0, 0, 0, 0, 1, 4'b0001, 32'd0,        32'h0,        32'h03030303);
    add(1, 0, 0, 0, 0, 4'b0001, 32'd0,        32'h0,        32'd1);
    add(1, 1, 1, 0, 0, 4'b0000, 32'd16,       32'h00000005, 32'h00000005);
    add(1, 0, 0, 0, 0, 4'b0010, 32'd0,        32'h0,        32'd2);
    add(1, 0, 0, 0, 0, 4'b0000, 32'd16,       32'h0,        32'h00000005);
    add(1, 1, 0, 0, 0, 4'b0000, 32'd9,        32'h0,        32'h0);
    add(1, 1, 0, 0, 1, 4'b0000, 32'd9,        32'h12345678, 32'h0);
    add(1, 0, 0, 0, 0, 4'b0000, 32'd9,        32'h0,        32'h0);
    add(1, 0, 0, 0, 0, 4'b1000, 32'd0,        32'h0,        32'h0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 4'b0000, 32'd0, 32'd0);
    #12;
    chk("reset_out", cim_output, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].cs, tbl[i].we, tbl[i].cime, tbl[i].ps, tbl[i].rso, tbl[i].oreg,
           tbl[i].addr, tbl[i].data, tbl[i].exp, $sformatf("vec%0d", i));

    // Asynchronous reset mid-sequence clears outputs and accumulators, not weights.
    step(1, 0, 1, 0, 0, 4'b0000, 32'd0, 32'h01010101, 32'h01010101, "pre_reset_read");
    drive(0, 0, 0, 0, 0, 4'b0000, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_out", cim_output, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 4'b0000, 32'd2, 32'h0, 32'h03030303, "weights_kept");
    step(1, 0, 0, 0, 0, 4'b0100, 32'd0, 32'h0, 32'h0,        "acc_cleared");

    // Overflow: acc0 = -16 + 32768*65536 = 0x7FFFFFF0, then +32.
    step(1, 1, 0, 0, 0, 4'b0000, 32'd4,  32'h00000080, 32'h00000080, "wr_r4");
    step(1, 1, 0, 0, 0, 4'b0000, 32'd5,  32'h00000080, 32'h00000080, "wr_r5");
    step(1, 1, 0, 0, 0, 4'b0000, 32'd6,  32'h00000080, 32'h00000080, "wr_r6");
    step(1, 1, 0, 0, 0, 4'b0000, 32'd7,  32'h00000080, 32'h00000080, "wr_r7");
    step(1, 1, 0, 0, 0, 4'b0000, 32'd8,  32'h00000001, 32'h00000001, "wr_r8");
    step(1, 1, 0, 0, 0, 4'b0000, 32'd10, 32'h0,        32'h0,        "wr_r10");
    step(1, 1, 0, 0, 0, 4'b0000, 32'd11, 32'h0,        32'h0,        "wr_r11");
    step(1, 0, 1, 0, 0, 4'b0001, 32'd8,  32'h000000F0, 32'hFFFFFFF0, "acc_minus16");
    drive(1, 0, 1, 1, 0, 4'b0001, 32'd4, 32'h80808080);
    for (int n = 0; n < 32768; n++) @(posedge clk);
    #1 chk("acc_near_max", cim_output, 32'h7FFFFFF0);
    @(negedge clk);
`ifdef CIM_SATURATE_EN
    step(1, 0, 1, 1, 0, 4'b0001, 32'd8, 32'h00000020, 32'h7FFFFFFF, "acc_overflow");
`else
    step(1, 0, 1, 1, 0, 4'b0001, 32'd8, 32'h00000020, 32'h80000010, "acc_overflow");
`endif
    step(1, 0, 1, 0, 0, 4'b0001, 32'd8, 32'h00000020, 32'h00000020, "overwrite_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/basic_gemm_cim.md
# basic_gemm_cim

Compute-in-memory GEMM macro attached to the darkriscv core's CIM port. It stores a 64×4 array of signed 8-bit weights and computes 4-input × 4-column int8 dot products in a single cycle. Results go into four 32-bit accumulators, optionally adding to the previous partial sum. The core drives all control strobes and reads results back over `cim_output`.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cs` in 1: chip select; when 0, all operations are ignored and every register holds.
- `we` in 1: weight write strobe.
- `cime` in 1: compute strobe.
- `partial_sum_e` in 1: 1 = accumulate into accumulators; 0 = overwrite them.
- `reset_output_reg` in 1: synchronous clear of all accumulators.
- `output_reg` in 4: one-hot accumulator select for `cim_output`.
- `address` in 32: `[5:0]` is the row address; bits `[31:6]` are ignored.
- `input_data` in 32: write data, or activations x_k = `input_data[8k+7:8k]` (signed), k = 0..3.
- `cim_output` out 32: registered read/result data.

## Operation
- Weight array: 64 rows × 32 bits. W[r][c] = row r bits `[8c+7:8c]`, signed int8, c = 0..3.
- Accumulators: acc[0..3], each 32-bit signed.
- Priority per edge when `cs`=1: `reset_output_reg` > `we` > `cime`.
  - Lower-priority strobes asserted in the same cycle are ignored entirely.
- Clear (`reset_output_reg`=1): acc[0..3] ← 0.
- Write (`we`=1): row `address[5:0]` ← `input_data`.
- Compute (`cime`=1):
  - base = {`address[5:2]`, 2'b00}; `address[1:0]` is ignored.
  - For each column c: S_c = Σ_{k=0..3} x_k × W[base+k][c].
  - Each product is 16-bit signed; the sum is 18-bit, sign-extended to 32 bits.
  - acc[c] ← acc[c] + S_c if `partial_sum_e`=1; else acc[c] ← S_c.
  - Addition wraps modulo 2^32 (see Configuration).
- Output register, updated on every edge with `cs`=1:
  - `output_reg`≠0: `cim_output` ← post-update value of acc[i], where i is the lowest set bit of `output_reg`.
  - `output_reg`=0: `cim_output` ← row `address[5:0]` (memory read).
    - Write-first: a write in the same cycle returns the new data.
- No operation strobes and `cs`=1: accumulators hold; `cim_output` still tracks the select/read path.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - acc[0..3] = 0 and `cim_output` = 0 immediately.
  - Weight array is not reset; its contents are preserved.
- Reset released mid-sequence: operations resume from the first rising edge with `rst_n`=1.
- Write, compute and clear each take effect at a single rising edge; no handshake, a new operation is accepted every cycle.
- Latency:
  - Compute result on `cim_output`: 1 edge (the same edge that samples `cime`).
  - Memory read: 1 edge.
- Back-to-back computes with `partial_sum_e`=1 chain without stalls.
- `cs`=0 edges are fully transparent: nothing changes, including `cim_output`.

## Configuration
- `CIM_SATURATE_EN` defined:
  - Accumulate saturates at 0x7FFFFFFF / 0x80000000 instead of wrapping.
  - The overwrite path is unaffected.
- `CIM_SATURATE_EN` undefined: two's-complement wrap modulo 2^32.

## Test plan
- Reset → `cim_output`=0. Then compute with `output_reg`=4'b0001 and `partial_sum_e`=1 on zero activations → `cim_output`=0.
- Weight write and readback:
  - Write rows 0..3 = 0x01010101, 0x02020202, 0x03030303, 0x04040404.
  - `output_reg`=0, `address`=2 → `cim_output`=0x03030303.
- Compute, overwrite:
  - `cime`, `address`=0, `input_data`=0x01010101, `partial_sum_e`=0, `output_reg`=4'b0100 → `cim_output`=10.
  - Repeat with `partial_sum_e`=1 → 20.
  - Then assert `reset_output_reg` together with `cime` → 0; the compute is ignored.
- Signed case: with the weights above, `input_data`=0x000000FF (x0=−1) → every column = 0xFFFFFFFF.
- Hold and priority:
  - `cs`=0 with `we`=1 → row unchanged and `cim_output` unchanged.
  - `we` and `cime` in the same cycle → only the write occurs.
- Overflow: set acc[0] to 0x7FFFFFF0 via repeated accumulates, then add +32 → 0x80000010 (wrap), or 0x7FFFFFFF with `CIM_SATURATE_EN`.
